// File: rtl/dm_sync.sv
// Synchronous-read data memory for the MEM stage: word/half/byte stores,
// signed/unsigned loads, zero sweep after reset and access checking.
module dm_sync #(
    parameter int DEPTH_LOG2     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dm_r,
    input  logic        dm_w,
    input  logic [2:0]  dm_type,
    input  logic [31:0] wd,
    input  logic [31:0] a1,
    output logic [31:0] rd1,
    output logic        rd_valid,
    output logic        busy,
    output logic        err
);

    localparam int WORDS = 2 ** DEPTH_LOG2;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                  state_reg;
    logic [DEPTH_LOG2-1:0]   clr_idx_reg;
    logic                    busy_reg;
    logic                    rd_valid_reg;
    logic                    err_reg;

    logic [31:0]             mem [WORDS];
    logic [31:0]             mem_rdata_reg;

    // Load-side context captured with the request, used to finish the load
    // one cycle later (lane select, extension and write-first merge).
    logic [31:0]             ld_wdata_reg;
    logic [3:0]              ld_be_reg;
    logic [2:0]              ld_type_reg;
    logic [1:0]              ld_lane_reg;
    logic                    ld_seen_reg;

    logic                    type_word, type_half, type_byte, type_ok;
    logic                    range_ok, align_ok, acc_ok, req;
    logic                    st_go, ld_go, rej, clr_we, mem_we;
    logic [DEPTH_LOG2-1:0]   word_idx, mem_addr;
    logic [3:0]              st_be, mem_be;
    logic [31:0]             st_data, mem_wdata, merged, ext_data;
    logic [15:0]             half_sel;
    logic [7:0]              byte_sel;

    always_comb begin
        type_word = (dm_type == 3'b000);
        type_half = (dm_type[2:1] == 2'b10);
        type_byte = (dm_type[2:1] == 2'b11);
        type_ok   = type_word | type_half | type_byte;
        range_ok  = ((a1 >> (DEPTH_LOG2 + 2)) == 32'd0);
        align_ok  = type_word ? (a1[1:0] == 2'b00) :
                    type_half ? ~a1[0] : 1'b1;
        acc_ok    = type_ok & range_ok & align_ok;
        req       = (dm_r | dm_w) & (state_reg == IDLE);
        st_go     = req & acc_ok & dm_w;
        ld_go     = req & acc_ok & dm_r;
        rej       = req & ~acc_ok;
        word_idx  = a1[DEPTH_LOG2+1:2];
        // Store data replicated across lanes; byte enables pick the target lane(s).
        st_data   = type_word ? wd :
                    type_half ? {2{wd[15:0]}} : {4{wd[7:0]}};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign st_be[gi] = type_word
                             | (type_half & (a1[1] == LANE[1]))
                             | (type_byte & (a1[1:0] == LANE));
            // Write-first: lanes written in the load cycle override the RAM output.
            assign merged[gi*8 +: 8] = ld_be_reg[gi] ? ld_wdata_reg[gi*8 +: 8]
                                                     : mem_rdata_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        clr_we    = (state_reg == CLEAR);
        mem_we    = clr_we | st_go;
        mem_addr  = clr_we ? clr_idx_reg : word_idx;
        mem_be    = clr_we ? 4'hF : st_be;
        mem_wdata = clr_we ? 32'd0 : st_data;
    end

    always_ff @(posedge clk) begin
        if (ld_go) begin
            mem_rdata_reg <= mem[word_idx];
        end
        for (int i = 0; i < 4; i++) begin
            if (mem_we && mem_be[i]) begin
                mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_idx_reg  <= '0;
            busy_reg     <= CLEAR_ON_RESET;
            rd_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
            ld_wdata_reg <= '0;
            ld_be_reg    <= '0;
            ld_type_reg  <= '0;
            ld_lane_reg  <= '0;
            ld_seen_reg  <= 1'b0;
        end else begin
            rd_valid_reg <= ld_go;
            err_reg      <= rej;
            if (state_reg == CLEAR) begin
                clr_idx_reg <= clr_idx_reg + 1'b1;
                if (clr_idx_reg == '1) begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            end
            if (ld_go) begin
                ld_seen_reg  <= 1'b1;
                ld_type_reg  <= dm_type;
                ld_lane_reg  <= a1[1:0];
                ld_be_reg    <= dm_w ? st_be : 4'h0;
                ld_wdata_reg <= st_data;
            end
        end
    end

    always_comb begin
        half_sel = ld_lane_reg[1] ? merged[31:16] : merged[15:0];
        byte_sel = merged[{ld_lane_reg, 3'b000} +: 8];
        case (ld_type_reg)
            3'b100:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext_data = {16'd0, half_sel};
            3'b110:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b111:  ext_data = {24'd0, byte_sel};
            default: ext_data = merged;
        endcase
    end

    // Before the first load the RAM output register holds no meaningful data.
    assign rd1      = ld_seen_reg ? ext_data : 32'd0;
    assign rd_valid = rd_valid_reg;
    assign busy     = busy_reg;
    assign err      = err_reg;

endmodule

// File: doc/dm_sync.md
# dm_sync

Parametrised, synchronous-read successor to the single-cycle data memory `dm`. It stores 2^DEPTH_LOG2 32-bit words and supports word, half and byte stores, plus signed and unsigned loads. After reset it sweeps the array to zero, and it flags misaligned, out-of-range or illegal-type accesses. It sits in the MEM stage of the MIPS datapath; the pipeline uses `rd_valid` to capture load data one cycle after issue.

## Interface
Parameters:
- DEPTH_LOG2, 10: log2 of word count; byte address space is 2^(DEPTH_LOG2+2) bytes.
- CLEAR_ON_RESET, 1: 1 = zero-sweep after reset; 0 = contents undefined, idle immediately.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- dm_r  in  1  load request.
- dm_w  in  1  store request.
- dm_type  in  3  000 word, 100 half, 101 half unsigned, 110 byte, 111 byte unsigned; other codes are illegal.
- wd  in  32  store data, right-justified.
- a1  in  32  byte address.
- rd1  out  32  load data, registered, extended to 32 bits.
- rd_valid  out  1  one-cycle pulse when rd1 holds new load data.
- busy  out  1  clear sweep in progress; requests are ignored while high.
- err  out  1  one-cycle pulse for a rejected access.

## Operation
- FSM states are CLEAR and IDLE.
- **Reset low (async):** state CLEAR (or IDLE if CLEAR_ON_RESET=0), sweep index 0, rd1=0, rd_valid=0, err=0, busy=1 (0 if CLEAR_ON_RESET=0).
- **CLEAR:** each edge writes 0 to word[idx], then idx++. After writing word 2^DEPTH_LOG2-1, go to IDLE and drop busy.
- **IDLE:** dm_r and dm_w are sampled each edge. A request with busy=1 is ignored: no write, no rd_valid, no err.
- **Endianness:** little-endian. Byte offset 0 = bits 7:0, offset 3 = bits 31:24.
- **Word index:** a1[DEPTH_LOG2+1:2].
- **Access checks:** an access is rejected if any of these holds:
  - a1[31:DEPTH_LOG2+2] is non-zero;
  - word access with a1[1:0] != 0;
  - half access with a1[0] != 0;
  - dm_type is illegal.
- **Rejected access:** no write occurs, rd1 holds its value, rd_valid=0, and err=1 on the next cycle.
- **Stores:**
  - word writes all four lanes from wd;
  - half writes lanes {a1[1],1}:{a1[1],0} from wd[15:0];
  - byte writes lane a1[1:0] from wd[7:0];
  - types 101 and 111 store as 100 and 110 respectively.
- **Loads:** select the half or byte at the same lanes. Signed types sign-extend; unsigned types zero-extend; word loads pass through.
- **dm_r and dm_w in the same cycle:** the write is performed, and the read returns the post-write word (write-first).

## Timing
- CLEAR_ON_RESET=1: busy stays high for exactly 2^DEPTH_LOG2 rising edges after reset deasserts. The first request accepted is the one sampled on the edge after busy falls.
- **Load latency:** 1 cycle. A request sampled at edge N gives rd1 and rd_valid=1 after edge N. rd_valid returns to 0 after edge N+1 unless a new load is accepted.
- **Back-to-back loads:** supported every cycle; rd_valid stays high continuously.
- **Store latency:** the word is updated at the sampling edge. A load in the following cycle sees the new data.
- **err:** asserted after the sampling edge of the rejected request; lasts one cycle per rejected request.
- **Reset during CLEAR or IDLE:** all outputs take their reset values immediately, and the sweep restarts from index 0.

## Test plan
- **Reset and sweep** (DEPTH_LOG2=10): pulse reset low. busy=1 for 1024 cycles, then 0. Load word a1=0x40 → next cycle rd1=0x00000000 with rd_valid=1.
- **Sign and zero extension:** sw wd=0xAAAAAAAA at a1=4, then:
  - lw 4 → 0xAAAAAAAA;
  - lh 6 → 0xFFFFAAAA;
  - lhu 6 → 0x0000AAAA;
  - lb 5 → 0xFFFFFFAA;
  - lbu 5 → 0x000000AA.
- **Partial stores** on cleared memory:
  - sh wd=0x00001234 at a1=10 → lw 8 = 0x12340000;
  - sb wd=0x0000005A at a1=15 → lw 12 = 0x5A000000;
  - lw 4 unchanged.
- **Errors:** each of the following gives err=1 for one cycle, rd_valid=0 and no memory change (lw 0 = 0):
  - sw at a1=1;
  - lh at a1=3;
  - dm_type=001;
  - lw at a1=0x1000.
- **Simultaneous read and write:** dm_r=dm_w=1, sw wd=0x11223344 at a1=0x20 → next cycle rd1=0x11223344, rd_valid=1.
- **Reset mid-sweep:** assert reset at sweep index 500 → outputs go to reset values at once. Deassert → busy high for another full 1024 cycles. A sw 0xFFFFFFFF issued at a1=0 while busy is ignored; after busy falls, lw 0 = 0.
